// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment capture path: segment patterns,
// pattern decode, converter state encoding and output width helper.
package seven_segment_pkg;

  // Active-low segment patterns, bit 7 = a ... bit 1 = g, bit 0 = dp (off).
  localparam logic [7:0] SEG_0 = 8'h03;
  localparam logic [7:0] SEG_1 = 8'h9F;
  localparam logic [7:0] SEG_2 = 8'h25;
  localparam logic [7:0] SEG_3 = 8'h0D;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h49;
  localparam logic [7:0] SEG_6 = 8'h41;
  localparam logic [7:0] SEG_7 = 8'h1F;
  localparam logic [7:0] SEG_8 = 8'h01;
  localparam logic [7:0] SEG_9 = 8'h09;
  localparam logic [7:0] SEG_A = 8'h11;
  localparam logic [7:0] SEG_B = 8'hC1;
  localparam logic [7:0] SEG_C = 8'h63;
  localparam logic [7:0] SEG_D = 8'h85;
  localparam logic [7:0] SEG_E = 8'h61;
  localparam logic [7:0] SEG_F = 8'h71;

  localparam logic [15:0][7:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_DONE
  } conv_state_t;

  function automatic int data_bits(input bit hex);
    return hex ? 16 : 14;
  endfunction

  // Returns {valid, nibble}; the decimal point is ignored.
  function automatic logic [4:0] seg_decode(input logic [7:0] seg, input bit hex);
    logic [4:0] res;
    res = '0;
    for (int n = 0; n < 16; n++) begin
      if ((hex || n < 10) && ((seg | 8'h01) == SEG_TABLE[n])) begin
        res = {1'b1, 4'(n)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seven_segment_capture_bcd_to_binary.sv
// Packed-BCD to binary converter (inverse of double_dabble). In hex mode the
// four nibbles are passed straight through as the result.
module bcd_to_binary
  import seven_segment_pkg::*;
#(
  parameter bit HEX       = 1'b0,
  parameter int DATA_BITS = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          bcd_in,
  input  logic                 bcd_valid,
  output logic                 ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_out_valid
);

  conv_state_t     state;
  logic [3:0][3:0] bcd_q;
  logic [13:0]     acc;
  logic [13:0]     acc_next;
  logic [1:0]      k;

  // acc*10 + digit; 9999 fits in 14 bits so no overflow handling is needed.
  assign acc_next = (acc << 3) + (acc << 1) + 14'(bcd_q[k]);
  assign ready    = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      bcd_q          <= '0;
      acc            <= '0;
      k              <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      data_out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bcd_valid) begin
            bcd_q <= bcd_in;
            acc   <= '0;
            k     <= 2'd3;
            if (HEX) begin
              data_out       <= DATA_BITS'(bcd_in);
              data_out_valid <= 1'b1;
              state          <= ST_DONE;
            end else begin
              state <= ST_CONVERT;
            end
          end
        end
        ST_CONVERT: begin
          acc <= acc_next;
          k   <= k - 2'd1;
          if (k == 2'd0) begin
            data_out       <= DATA_BITS'(acc_next);
            data_out_valid <= 1'b1;
            state          <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seven_segment_capture.sv
// Receive side of a multiplexed four-digit seven-segment display: samples each
// digit after its anode has settled and reports the completed frame value.
module seven_segment_capture
  import seven_segment_pkg::*;
#(
  parameter bit    HEX           = 1'b0,
  parameter int    SETTLE_CYCLES = 4,
  localparam int   DATA_BITS     = data_bits(HEX)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           enable,
  input  logic [7:0]           led_out,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_out_valid,
  output logic                 digit_error
);

  logic [3:0]      en_q;
  logic [7:0]      seg_q;
  logic [7:0]      settle_cnt;
  logic [3:0]      seen;
  logic [3:0]      seen_next;
  logic [3:0][3:0] digit;
  logic [1:0]      idx;
  logic [4:0]      dec;
  logic            one_cold;
  logic            multi_low;
  logic            strobe;
  logic            conv_ready;
  logic            latch;

  assign one_cold  = $onehot(~en_q);
  assign multi_low = !one_cold && (en_q != 4'hF);
  assign strobe    = one_cold && (settle_cnt == 8'(SETTLE_CYCLES - 1));
  assign dec       = seg_decode(seg_q, HEX);
  assign latch     = conv_ready && (seen == 4'hF);

  always_comb begin
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!en_q[i]) idx = 2'(i);
    end
  end

  // A sample landing in the latch cycle keeps its seen bit for the next frame.
  always_comb begin
    seen_next = latch ? 4'h0 : seen;
    if (strobe) seen_next[idx] = dec[4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q        <= 4'hF;
      seg_q       <= 8'hFF;
      settle_cnt  <= '0;
      seen        <= '0;
      digit       <= '0;
      digit_error <= 1'b0;
    end else begin
      en_q  <= enable;
      seg_q <= led_out;
      if (enable != en_q) begin
        settle_cnt <= '0;
      end else if (settle_cnt != 8'(SETTLE_CYCLES)) begin
        settle_cnt <= settle_cnt + 8'd1;
      end
      seen <= seen_next;
      if (strobe && dec[4]) digit[idx] <= dec[3:0];
      // The counter is only zero right after en_q takes a new value.
      digit_error <= (strobe && !dec[4]) || (multi_low && settle_cnt == 8'd0);
    end
  end

  bcd_to_binary #(
    .HEX      (HEX),
    .DATA_BITS(DATA_BITS)
  ) u_conv (
    .clk           (clk),
    .reset         (reset),
    .bcd_in        (digit),
    .bcd_valid     (seen == 4'hF),
    .ready         (conv_ready),
    .data_out      (data_out),
    .data_out_valid(data_out_valid)
  );

endmodule

// File: tb/tb_seven_segment_capture.sv
// Bench for seven_segment_capture: decimal, hex and fast-settle instances share
// one stimulus stream and are checked every cycle against a frame-level model.
module tb_seven_segment_capture;

  localparam int NI = 3;
  localparam bit HEXP [NI] = '{1'b0, 1'b1, 1'b1};
  localparam int SP   [NI] = '{4, 4, 1};
  localparam logic [7:0] PAT [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  enable = 4'hF;
  logic [7:0]  led_out = 8'hFF;
  logic [13:0] data_dec;
  logic [15:0] data_hex, data_fast;
  logic        vld_dec, vld_hex, vld_fast;
  logic        err_dec, err_hex, err_fast;

  always #5 clk = ~clk;

  seven_segment_capture #(.HEX(1'b0), .SETTLE_CYCLES(4)) dut_dec (
    .clk(clk), .reset(reset), .enable(enable), .led_out(led_out),
    .data_out(data_dec), .data_out_valid(vld_dec), .digit_error(err_dec));
  seven_segment_capture #(.HEX(1'b1), .SETTLE_CYCLES(4)) dut_hex (
    .clk(clk), .reset(reset), .enable(enable), .led_out(led_out),
    .data_out(data_hex), .data_out_valid(vld_hex), .digit_error(err_hex));
  seven_segment_capture #(.HEX(1'b1), .SETTLE_CYCLES(1)) dut_fast (
    .clk(clk), .reset(reset), .enable(enable), .led_out(led_out),
    .data_out(data_fast), .data_out_valid(vld_fast), .digit_error(err_fast));

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [7:0] seg, input bit hex);
    logic [4:0] r;
    r = 5'h0;
    for (int n = 0; n < 16; n++)
      if ((hex || n < 10) && ((seg | 8'h01) == PAT[n])) r = {1'b1, 4'(n)};
    return r;
  endfunction

  function automatic logic [15:0] got_data(input int h);
    case (h)
      0: return {2'b00, data_dec};
      1: return data_hex;
      default: return data_fast;
    endcase
  endfunction

  function automatic logic got_vld(input int h);
    case (h)
      0: return vld_dec;
      1: return vld_hex;
      default: return vld_fast;
    endcase
  endfunction

  function automatic logic got_err(input int h);
    case (h)
      0: return err_dec;
      1: return err_hex;
      default: return err_fast;
    endcase
  endfunction

  // Model state: frame bookkeeping per instance plus a ring of future events.
  int          cyc = 0;
  bit          started = 1'b0;
  logic [3:0]  m_prev_en;
  int          m_run;
  logic [3:0]  m_seen [NI];
  logic [3:0]  m_dig  [NI][4];
  int          m_free [NI];
  int          m_fill [NI] = '{-1, -1, -1};
  logic        s_vld  [NI][64];
  logic [15:0] s_val  [NI][64];
  logic        s_err  [NI][64];
  logic [15:0] exp_data [NI];
  int          cnt_vld [NI];
  int          cnt_err [NI];
  int          last_vld_cyc [NI];
  logic [15:0] last_data [NI];
  string       NM [NI] = '{"dec", "hex", "fast"};

  initial begin : model
    logic       ev_vld [NI];
    logic       ev_err [NI];
    logic [4:0] d;
    logic [15:0] val;
    int         i, sl;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int h = 0; h < NI; h++) begin
        ev_vld[h] = 1'b0;
        ev_err[h] = 1'b0;
      end
      if (reset) begin
        started   = 1'b1;
        m_prev_en = 4'hF;
        m_run     = 1;
        for (int h = 0; h < NI; h++) begin
          m_seen[h]   = 4'h0;
          m_free[h]   = cyc;
          exp_data[h] = 16'h0;
          for (int s = 0; s < 64; s++) begin
            s_vld[h][s] = 1'b0;
            s_err[h][s] = 1'b0;
          end
        end
      end else if (started) begin
        sl = cyc % 64;
        for (int h = 0; h < NI; h++) begin
          ev_vld[h] = s_vld[h][sl];
          ev_err[h] = s_err[h][sl];
          if (s_vld[h][sl]) exp_data[h] = s_val[h][sl];
          s_vld[h][sl] = 1'b0;
          s_err[h][sl] = 1'b0;
        end
        if (enable == m_prev_en) m_run++;
        else begin
          m_prev_en = enable;
          m_run = 1;
        end
        if ($countones(~enable) >= 2 && m_run == 1)
          for (int h = 0; h < NI; h++) s_err[h][(cyc + 1) % 64] = 1'b1;
        i = 0;
        for (int b = 0; b < 4; b++) if (!enable[b]) i = b;
        for (int h = 0; h < NI; h++) begin
          if (m_seen[h] == 4'hF && cyc >= m_free[h]) begin
            if (HEXP[h]) val = {m_dig[h][3], m_dig[h][2], m_dig[h][1], m_dig[h][0]};
            else val = 16'(m_dig[h][3] * 1000 + m_dig[h][2] * 100 + m_dig[h][1] * 10 + m_dig[h][0]);
            s_vld[h][(cyc + (HEXP[h] ? 1 : 5)) % 64] = 1'b1;
            s_val[h][(cyc + (HEXP[h] ? 1 : 5)) % 64] = val;
            m_free[h] = cyc + (HEXP[h] ? 2 : 6);
            m_seen[h] = 4'h0;
          end
          if ($countones(~enable) == 1 && m_run == SP[h]) begin
            d = ref_decode(led_out, HEXP[h]);
            if (d[4]) begin
              m_dig[h][i]  = d[3:0];
              m_seen[h][i] = 1'b1;
              if (m_seen[h] == 4'hF) m_fill[h] = cyc;
            end else begin
              m_seen[h][i] = 1'b0;
              s_err[h][(cyc + 1) % 64] = 1'b1;
            end
          end
        end
      end
      if (started) begin
        for (int h = 0; h < NI; h++) begin
          chk({NM[h], "_valid"}, 32'(got_vld(h)), 32'(ev_vld[h]));
          chk({NM[h], "_error"}, 32'(got_err(h)), 32'(ev_err[h]));
          chk({NM[h], "_data"},  32'(got_data(h)), 32'(exp_data[h]));
          if (got_vld(h) === 1'b1) begin
            cnt_vld[h]++;
            last_vld_cyc[h] = cyc;
            last_data[h] = got_data(h);
          end
          if (got_err(h) === 1'b1) cnt_err[h]++;
        end
      end
    end
  end

  task automatic drive(input logic [3:0] en, input logic [7:0] seg, input int n);
    @(negedge clk);
    enable = en;
    led_out = seg;
    repeat (n - 1) @(negedge clk);
  endtask

  function automatic logic [3:0] sel(input int i);
    logic [3:0] one;
    one = 4'b0001 << i;
    return ~one;
  endfunction

  task automatic scan(input logic [7:0] s0, input logic [7:0] s1,
                      input logic [7:0] s2, input logic [7:0] s3, input int dwell);
    drive(sel(0), s0, dwell);
    drive(sel(1), s1, dwell);
    drive(sel(2), s2, dwell);
    drive(sel(3), s3, dwell);
  endtask

  task automatic clear_obs();
    for (int h = 0; h < NI; h++) begin
      cnt_vld[h] = 0;
      cnt_err[h] = 0;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    enable = 4'hF;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : main
    int old_fill, n;
    logic [3:0] ill;
    logic [7:0] s;
    int pick, r;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_data", 32'(data_dec), 32'h0);
    chk("rst_valid", 32'(vld_dec), 32'h0);
    chk("rst_error", 32'(err_hex), 32'h0);

    clear_obs();
    scan(PAT[4], PAT[3], PAT[2], PAT[1], 8);
    drive(4'hF, 8'hFF, 10);
    chk("dec_1234", 32'(last_data[0]), 32'd1234);
    chk("dec_latency", 32'(last_vld_cyc[0] - m_fill[0]), 32'd6);
    chk("dec_count", 32'(cnt_vld[0]), 32'd1);
    chk("hex_1234", 32'(last_data[1]), 32'h1234);
    chk("fast_1234", 32'(last_data[2]), 32'h1234);

    clear_obs();
    scan(PAT[15], PAT[14], PAT[14], PAT[11], 8);
    drive(4'hF, 8'hFF, 10);
    chk("hex_beef", 32'(last_data[1]), 32'hBEEF);
    chk("hex_latency", 32'(last_vld_cyc[1] - m_fill[1]), 32'd2);
    chk("dec_af_valid", 32'(cnt_vld[0]), 32'd0);
    chk("dec_af_errors", 32'(cnt_err[0]), 32'd4);

    clear_obs();
    scan(PAT[5], PAT[6], 8'h11, PAT[7], 8);
    drive(4'hF, 8'hFF, 8);
    chk("bad_digit_err", 32'(cnt_err[0]), 32'd1);
    chk("bad_digit_valid", 32'(cnt_vld[0]), 32'd0);
    drive(sel(2), PAT[8], 8);
    drive(4'hF, 8'hFF, 10);
    chk("rescan_valid", 32'(cnt_vld[0]), 32'd1);
    chk("rescan_data", 32'(last_data[0]), 32'd7865);

    clear_obs();
    scan(PAT[1], PAT[2], PAT[3], PAT[4], 3);
    drive(4'hF, 8'hFF, 10);
    chk("short_dwell_dec_valid", 32'(cnt_vld[0]), 32'd0);
    chk("short_dwell_hex_valid", 32'(cnt_vld[1]), 32'd0);
    chk("short_dwell_errors", 32'(cnt_err[0] + cnt_err[1]), 32'd0);

    clear_obs();
    drive(4'b0011, PAT[0], 6);
    drive(4'hF, 8'hFF, 6);
    chk("multi_en_err_dec", 32'(cnt_err[0]), 32'd1);
    chk("multi_en_err_fast", 32'(cnt_err[2]), 32'd1);
    chk("multi_en_valid", 32'(cnt_vld[0] + cnt_vld[1] + cnt_vld[2]), 32'd0);

    pulse_reset();
    clear_obs();
    scan(PAT[1], PAT[2], PAT[3], PAT[4], 1);
    drive(sel(0), PAT[9], 1);
    drive(sel(1), PAT[2], 1);
    drive(sel(2), PAT[3], 1);
    drive(sel(3), PAT[4], 1);
    drive(4'hF, 8'hFF, 10);
    chk("coincide_count", 32'(cnt_vld[2]), 32'd2);
    chk("coincide_data", 32'(last_data[2]), 32'h4329);

    clear_obs();
    old_fill = m_fill[0];
    drive(sel(0), PAT[9], 8);
    drive(sel(1), PAT[9], 8);
    drive(sel(2), PAT[9], 8);
    @(negedge clk);
    enable = sel(3);
    led_out = PAT[9];
    n = 0;
    while (m_fill[0] == old_fill && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("fill_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    enable = 4'hF;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_valid", 32'(cnt_vld[0]), 32'd0);
    chk("abort_data", 32'(data_dec), 32'd0);
    scan(PAT[9], PAT[9], PAT[9], PAT[9], 8);
    drive(4'hF, 8'hFF, 10);
    chk("after_abort_9999", 32'(last_data[0]), 32'h270F);

    for (int it = 0; it < 220; it++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        pulse_reset();
      end else if (r < 10) begin
        ill = 4'($urandom_range(0, 15));
        while ($countones(~ill) < 2) ill = 4'($urandom_range(0, 15));
        drive(ill, 8'($urandom_range(0, 255)), $urandom_range(1, 6));
      end else if (r < 15) begin
        drive(4'hF, 8'hFF, $urandom_range(1, 8));
      end else begin
        for (int dg = 0; dg < 4; dg++) begin
          pick = $urandom_range(0, 99);
          if (pick < 75) s = PAT[$urandom_range(0, 9)] ^ 8'($urandom_range(0, 1));
          else if (pick < 88) s = PAT[$urandom_range(10, 15)];
          else s = 8'($urandom_range(0, 255));
          n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : dg;
          drive(sel(n), s, $urandom_range(1, 9));
          if ($urandom_range(0, 4) == 0) drive(sel(n), PAT[$urandom_range(0, 15)], $urandom_range(1, 4));
        end
      end
    end
    drive(4'hF, 8'hFF, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
